fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/fifo_uart_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed 8N1 UART transmitter.
// The line-level helper maps an FSM state to the serial level it drives.
package fifo_uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;
    localparam int BIT_IDX_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    function automatic logic line_level(input state_e st, input logic data_bit);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period; clear forces it back to zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls bytes from an upstream FIFO and sends them as 8N1 frames, LSB first.
// All outputs come from flops; TX trails the FSM state by one cycle.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              FIFO_EMPTY,
    input  logic [DATA_W-1:0] FIFO_OUT,
    input  logic              FIFO_WR_EN,
    output logic              FIFO_RD_EN,
    output logic              TX,
    output logic              BUSY,
    output logic              TX_DONE
);

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   rd_en_q, rd_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic bit_tick;
    logic timer_clear;
    logic timer_en;

    assign timer_en    = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign timer_clear = (state_d != state_q);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (SYSCLK),
        .rst      (RST),
        .clear    (timer_clear),
        .enable   (timer_en),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!FIFO_EMPTY) begin
                    state_d = ST_READ;
                end
            end
            // A same-cycle write wins inside the FIFO, so the read is dropped and retried.
            ST_READ: begin
                state_d = FIFO_WR_EN ? ST_IDLE : ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = FIFO_OUT;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (bit_idx_q == BIT_IDX_W'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_en_d = (state_d == ST_READ);
        busy_d  = (state_d != ST_IDLE);
        tx_d    = line_level(state_q, shift_q[0]);
    end

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign FIFO_RD_EN = rd_en_q;
    assign TX         = tx_q;
    assign BUSY       = busy_q;
    assign TX_DONE    = done_q;

endmodule
